// File: rtl/pwr_seq_ctrl.sv
// rtl/pwr_seq_ctrl.sv - four-channel regulator enable sequencer with over-current fault latching
// Optional: define PWR_SEQ_GLOBAL_SHUTDOWN_EN to drop every enable on any fault.
module pwr_seq_ctrl #(
  parameter int SETTLE_CYCLES = 1000,
  parameter int DEBOUNCE      = 16
) (
  input  logic       BUS_CLK,
  input  logic       BUS_RST,
  input  logic [3:0] ENABLE_REQ,
  input  logic [3:0] OC,
  input  logic [3:0] OC_CLEAR,
  output logic [3:0] EN,
  output logic [3:0] OC_LATCHED,
  output logic       BUSY
);

  typedef enum logic {IDLE, SETTLE} state_t;

  localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYCLES - 1);
  localparam logic [7:0]  DB_MAX      = 8'(DEBOUNCE);

  state_t      state, state_nxt;
  logic [15:0] settle_cnt, settle_nxt;
  logic [3:0]  en_nxt, latched_nxt;
  logic [3:0]  oc_meta, oc_s;
  logic [3:0]  target, turn_off, turn_on, fault;
  logic [1:0]  off_idx, on_idx;
  logic [7:0]  db_cnt [4];

  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      oc_meta <= '0;
      oc_s    <= '0;
    end else begin
      oc_meta <= OC;
      oc_s    <= oc_meta;
    end
  end

  // Counters only run while the channel is actually powered; they hold at DB_MAX.
  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      for (int k = 0; k < 4; k++) db_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (oc_s[k] && EN[k]) begin
          if (db_cnt[k] != DB_MAX) db_cnt[k] <= db_cnt[k] + 8'd1;
        end else begin
          db_cnt[k] <= '0;
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) fault[k] = (db_cnt[k] == DB_MAX);
  end

  assign target   = ENABLE_REQ & ~OC_LATCHED;
  assign turn_off = EN & ~target;
  assign turn_on  = ~EN & target;

  // Highest pending turn-off, lowest pending turn-on.
  always_comb begin
    off_idx = '0;
    on_idx  = '0;
    for (int k = 0; k < 4; k++) begin
      if (turn_off[k]) off_idx = 2'(k);
    end
    for (int k = 3; k >= 0; k--) begin
      if (turn_on[k]) on_idx = 2'(k);
    end
  end

  always_comb begin
    state_nxt  = state;
    settle_nxt = settle_cnt;
    en_nxt     = EN;
    case (state)
      IDLE: begin
        if (|turn_off) begin
          en_nxt[off_idx] = 1'b0;
          settle_nxt      = SETTLE_LOAD;
          state_nxt       = SETTLE;
        end else if (|turn_on) begin
          en_nxt[on_idx] = 1'b1;
          settle_nxt     = SETTLE_LOAD;
          state_nxt      = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt == '0) state_nxt = IDLE;
        else                  settle_nxt = settle_cnt - 16'd1;
      end
      default: state_nxt = IDLE;
    endcase
`ifdef PWR_SEQ_GLOBAL_SHUTDOWN_EN
    if (|fault) begin
      en_nxt     = '0;
      state_nxt  = IDLE;
      settle_nxt = '0;
    end
`else
    en_nxt = en_nxt & ~fault;
`endif
    // A fault set on the same edge as a clear request wins.
    latched_nxt = (OC_LATCHED & ~(OC_CLEAR & ~oc_s)) | fault;
  end

  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      state      <= IDLE;
      settle_cnt <= '0;
      EN         <= '0;
      OC_LATCHED <= '0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_nxt;
      EN         <= en_nxt;
      OC_LATCHED <= latched_nxt;
    end
  end

  assign BUSY = (state == SETTLE);

endmodule

// File: tb/tb_pwr_seq_ctrl.sv
// tb/tb_pwr_seq_ctrl.sv - directed self-checking bench for pwr_seq_ctrl (SETTLE_CYCLES=10, DEBOUNCE=4)
module tb_pwr_seq_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] enable_req;
  logic [3:0] oc;
  logic [3:0] oc_clear;
  logic [3:0] en;
  logic [3:0] oc_latched;
  logic       busy;

  int vectors;
  int miscompares;

`ifdef PWR_SEQ_GLOBAL_SHUTDOWN_EN
  localparam logic [3:0] FAULT_EN = 4'h0;
`else
  localparam logic [3:0] FAULT_EN = 4'hB;
`endif

  pwr_seq_ctrl #(.SETTLE_CYCLES(10), .DEBOUNCE(4)) dut (
    .BUS_CLK    (clk),
    .BUS_RST    (rst),
    .ENABLE_REQ (enable_req),
    .OC         (oc),
    .OC_CLEAR   (oc_clear),
    .EN         (en),
    .OC_LATCHED (oc_latched),
    .BUSY       (busy)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    vectors++;
    if (en !== 4'h0 || oc_latched !== 4'h0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: en=%h latched=%h busy=%b, want 0/0/0", en, oc_latched, busy);
    end
    rst = 1'b0;
    step(2);
    vectors++;
    if (en !== 4'h0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset: en=%h busy=%b, want 0/0", en, busy);
    end
  endtask

  task automatic test_power_up();
    logic [3:0] exp_en;
    logic       exp_busy;
    enable_req = 4'hF;
    for (int i = 1; i <= 44; i++) begin
      step(1);
      exp_en   = 4'((1 << ((i - 1) / 11 + 1)) - 1);
      exp_busy = ((i - 1) % 11) < 10;
      vectors++;
      if (en !== exp_en || busy !== exp_busy) begin
        miscompares++;
        $display("FAIL power_up cycle %0d: en=%h busy=%b, want %h/%b", i, en, busy, exp_en, exp_busy);
      end
    end
  endtask

  task automatic test_power_down();
    logic [3:0] exp_en;
    logic       exp_busy;
    enable_req = 4'h0;
    for (int i = 1; i <= 44; i++) begin
      step(1);
      exp_en   = 4'(15 >> ((i - 1) / 11 + 1));
      exp_busy = ((i - 1) % 11) < 10;
      vectors++;
      if (en !== exp_en || busy !== exp_busy) begin
        miscompares++;
        $display("FAIL power_down cycle %0d: en=%h busy=%b, want %h/%b", i, en, busy, exp_en, exp_busy);
      end
    end
  endtask

  task automatic test_fault();
    enable_req = 4'hF;
    step(44);
    vectors++;
    if (en !== 4'hF) begin
      miscompares++;
      $display("FAIL fault_setup: en=%h, want f", en);
    end
    oc = 4'h4;
    step(3);
    oc = 4'h0;
    step(10);
    vectors++;
    if (oc_latched !== 4'h0 || en !== 4'hF) begin
      miscompares++;
      $display("FAIL short_glitch: latched=%h en=%h, want 0/f", oc_latched, en);
    end
    oc = 4'h4;
    step(6);
    oc = 4'h0;
    vectors++;
    if (oc_latched !== 4'h0 || en !== 4'hF) begin
      miscompares++;
      $display("FAIL pre_latch: latched=%h en=%h, want 0/f", oc_latched, en);
    end
    step(1);
    vectors++;
    if (oc_latched !== 4'h4 || en !== FAULT_EN) begin
      miscompares++;
      $display("FAIL fault_latch: latched=%h en=%h, want 4/%h", oc_latched, en, FAULT_EN);
    end
    step(15);
    vectors++;
    if (oc_latched !== 4'h4 || en !== 4'hB || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL fault_hold: latched=%h en=%h busy=%b, want 4/b/0", oc_latched, en, busy);
    end
  endtask

  task automatic test_clear();
    oc = 4'h4;
    step(3);
    oc_clear = 4'h4;
    step(1);
    oc_clear = 4'h0;
    vectors++;
    if (oc_latched !== 4'h4) begin
      miscompares++;
      $display("FAIL clear_while_oc: latched=%h, want 4", oc_latched);
    end
    oc = 4'h0;
    step(3);
    oc_clear = 4'h4;
    step(1);
    oc_clear = 4'h0;
    vectors++;
    if (oc_latched !== 4'h0 || en !== 4'hB) begin
      miscompares++;
      $display("FAIL clear_ok: latched=%h en=%h, want 0/b", oc_latched, en);
    end
    step(1);
    vectors++;
    if (en !== 4'hF || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL reenable: en=%h busy=%b, want f/1", en, busy);
    end
  endtask

  task automatic test_reset_mid_settle();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    enable_req = 4'h3;
    step(12);
    vectors++;
    if (en !== 4'h3 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL settle_ch1: en=%h busy=%b, want 3/1", en, busy);
    end
    step(3);
    rst = 1'b1;
    #1;
    vectors++;
    if (en !== 4'h0 || busy !== 1'b0 || oc_latched !== 4'h0) begin
      miscompares++;
      $display("FAIL async_reset: en=%h busy=%b latched=%h, want 0/0/0", en, busy, oc_latched);
    end
    step(1);
    rst = 1'b0;
    step(1);
    vectors++;
    if (en !== 4'h1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL restart_ch0: en=%h busy=%b, want 1/1", en, busy);
    end
  endtask

  initial begin
    clk         = 1'b0;
    rst         = 1'b1;
    enable_req  = 4'h0;
    oc          = 4'h0;
    oc_clear    = 4'h0;
    vectors     = 0;
    miscompares = 0;
    step(2);
    test_reset();
    test_power_up();
    test_power_down();
    test_fault();
    test_clear();
    test_reset_mid_settle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
